// File: rtl/mux_rr_arbiter_pkg.sv
// arb_pkg: shared constants, FSM state type and index/one-hot helpers for
// the mux_rr_arbiter block. The optional ARB_LOCK_EN build does not change
// anything in this package.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // 2-bit index to 4-bit one-hot.
  function automatic logic [NREQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  // 4-bit one-hot to 2-bit index; non-one-hot input maps to 0.
  function automatic logic [SEL_W-1:0] enc4(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/ack handshake and mux-select bundle between the
// requesters, the downstream port and the arbiter. When ARB_LOCK_EN is
// defined the bundle also carries the per-requester lock inputs.
interface mux_rr_arbiter_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic             down_ready;
  logic [SEL_W-1:0] sel;
  logic [NREQ-1:0]  grant;
  logic             out_valid;
  logic [NREQ-1:0]  ack;
  logic             busy;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]  lock;

  // Arbiter side.
  modport master (
    input  req, down_ready, lock,
    output sel, grant, out_valid, ack, busy
  );

  // Requester / datapath side.
  modport slave (
    output req, down_ready, lock,
    input  sel, grant, out_valid, ack, busy
  );
`else
  // Arbiter side.
  modport master (
    input  req, down_ready,
    output sel, grant, out_valid, ack, busy
  );

  // Requester / datapath side.
  modport slave (
    output req, down_ready,
    input  sel, grant, out_valid, ack, busy
  );
`endif

endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker. Returns the first set bit of
// (req & ~mask) scanning from ptr upward modulo 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [NREQ-1:0] masked_s;
  logic [NREQ-1:0] rot_s;
  logic [NREQ-1:0] first_s;

  // Rotate so bit 0 is the ptr position, isolate the lowest set bit, rotate index back.
  always_comb begin
    masked_s = req & ~mask;
    case (ptr)
      2'd0:    rot_s = masked_s;
      2'd1:    rot_s = {masked_s[0],   masked_s[3:1]};
      2'd2:    rot_s = {masked_s[1:0], masked_s[3:2]};
      2'd3:    rot_s = {masked_s[2:0], masked_s[3]};
      default: rot_s = masked_s;
    endcase
    first_s = rot_s & (~rot_s + 4'd1);
    idx     = ptr + enc4(first_s);
    found   = (masked_s != 4'b0000);
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 32-bit downstream port for
// four requesters, with bounded bursts of HOLD_MAX accepted beats per grant.
// Optional feature macro: ARB_LOCK_EN (adds per-requester lock that suppresses
// the burst limit while the owner's lock bit is high).
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux_rr_arbiter_if.master   bus
);

  localparam logic [CNT_W:0] HOLD_LIM = (CNT_W+1)'(HOLD_MAX);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             busy_q,  busy_d;

  logic             vld_s;
  logic             acc_s;
  logic             lock_s;
  logic             release_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic [SEL_W-1:0] pick_ptr_s;
  logic [NREQ-1:0]  pick_mask_s;
  logic [SEL_W-1:0] pick_idx_s;
  logic             pick_found_s;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr_s),
    .mask  (pick_mask_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Beat acceptance, release decision and picker inputs for this cycle.
  always_comb begin
    vld_s       = 1'b0;
    acc_s       = 1'b0;
    release_s   = 1'b0;
    pick_ptr_s  = ptr_q;
    pick_mask_s = 4'b0000;
    cnt_inc_s   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
`ifdef ARB_LOCK_EN
    lock_s      = bus.lock[owner_q];
`else
    lock_s      = 1'b0;
`endif
    if (state_q == OWN) begin
      vld_s      = bus.req[owner_q];
      acc_s      = vld_s & bus.down_ready;
      // A release re-picks from the slot after the owner, so scan from there.
      pick_ptr_s = owner_q + 2'd1;
      if (!vld_s) begin
        // Owner dropped its request: release without ack, exclude it from the re-pick.
        release_s   = 1'b1;
        pick_mask_s = onehot2(owner_q);
      end else if (acc_s && !lock_s) begin
        release_s = (cnt_inc_s >= HOLD_LIM);
      end else begin
        release_s = 1'b0;
      end
    end else begin
      pick_ptr_s = ptr_q;
    end
  end

  // Next-state logic: grant from IDLE, hand over on release, count accepted beats.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = OWN;
          owner_d = pick_idx_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          ptr_d = owner_q + 2'd1;
          cnt_d = {CNT_W{1'b0}};
          if (pick_found_s) begin
            state_d = OWN;
            owner_d = pick_idx_s;
          end else begin
            state_d = IDLE;
          end
        end else if (acc_s) begin
          // Under lock the count saturates at the burst limit.
          if (cnt_inc_s > HOLD_LIM) begin
            cnt_d = HOLD_LIM[CNT_W-1:0];
          end else begin
            cnt_d = cnt_inc_s[CNT_W-1:0];
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    if (state_d == OWN) begin
      grant_d = onehot2(owner_d);
      busy_d  = 1'b1;
    end else begin
      grant_d = 4'b0000;
      busy_d  = 1'b0;
    end
  end

  // State and registered grant/busy, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  // Output drive: sel follows the registered owner and holds it while idle.
  always_comb begin
    bus.sel       = owner_q;
    bus.grant     = grant_q;
    bus.busy      = busy_q;
    bus.out_valid = vld_s;
    if (acc_s) begin
      bus.ack = onehot2(owner_q);
    end else begin
      bus.ack = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed-vector bench for mux_rr_arbiter with
// hand-computed expectations. A second instance with HOLD_MAX=1 shares the
// stimulus to check strict per-beat rotation. The lock scenario runs only
// when ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mux_rr_arbiter_if bus0();
  mux_rr_arbiter_if bus1();

  mux_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mux_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  assign bus1.req        = bus0.req;
  assign bus1.down_ready = bus0.down_ready;
`ifdef ARB_LOCK_EN
  assign bus1.lock       = 4'b0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [1:0] e_sel;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus0.req = 4'b1111;
    bus0.down_ready = 1'b1;
`ifdef ARB_LOCK_EN
    bus0.lock = 4'b0000;
`endif
    tick();
    tick();
    chk("rst_grant", 32'(bus0.grant), 32'h0);
    chk("rst_sel", 32'(bus0.sel), 32'h0);
    chk("rst_valid", 32'(bus0.out_valid), 32'h0);
    chk("rst_ack", 32'(bus0.ack), 32'h0);
    chk("rst_busy", 32'(bus0.busy), 32'h0);

    // Single requester: continuous acks, grant never moves.
    bus0.req = 4'b0010;
    rst = 1'b0;
    #1;
    chk("single_latency", 32'(bus0.grant), 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("single_grant", 32'(bus0.grant), 32'h2);
      chk("single_ack", 32'(bus0.ack), 32'h2);
      chk("single_sel", 32'(bus0.sel), 32'h1);
      tick();
    end
    bus0.req = 4'b0000;
    #1;
    chk("drop_ack", 32'(bus0.ack), 32'h0);
    chk("drop_valid", 32'(bus0.out_valid), 32'h0);
    tick();
    chk("idle_grant", 32'(bus0.grant), 32'h0);
    chk("idle_busy", 32'(bus0.busy), 32'h0);
    chk("idle_sel_hold", 32'(bus0.sel), 32'h1);

    // Fairness: bursts of 4 on dut0, per-beat rotation on dut1, no bubbles.
    rst_pulse();
    bus0.req = 4'b1111;
    bus0.down_ready = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      e_sel = 2'((k / 4) % 4);
      chk("fair_sel", 32'(bus0.sel), 32'(e_sel));
      chk("fair_ack", 32'(bus0.ack), 32'(4'b0001 << e_sel));
      e_sel = 2'(k % 4);
      chk("hold1_sel", 32'(bus1.sel), 32'(e_sel));
      chk("hold1_ack", 32'(bus1.ack), 32'(4'b0001 << e_sel));
      tick();
    end

    // Backpressure: owner 3 with two beats done, stalled for five cycles.
    rst_pulse();
    bus0.req = 4'b1000;
    tick();
    chk("bp_grant", 32'(bus0.grant), 32'h8);
    chk("bp_ack0", 32'(bus0.ack), 32'h8);
    tick();
    chk("bp_ack1", 32'(bus0.ack), 32'h8);
    tick();
    bus0.down_ready = 1'b0;
    bus0.req = 4'b1111;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_stall_ack", 32'(bus0.ack), 32'h0);
      chk("bp_stall_grant", 32'(bus0.grant), 32'h8);
      chk("bp_stall_sel", 32'(bus0.sel), 32'h3);
      chk("bp_stall_valid", 32'(bus0.out_valid), 32'h1);
      tick();
    end
    bus0.down_ready = 1'b1;
    #1;
    chk("bp_resume_ack2", 32'(bus0.ack), 32'h8);
    tick();
    chk("bp_resume_ack3", 32'(bus0.ack), 32'h8);
    tick();
    chk("bp_wrap_grant", 32'(bus0.grant), 32'h1);
    chk("bp_wrap_sel", 32'(bus0.sel), 32'h0);

    // Early drop: owner 1 drops after two acks, requester 2 waiting.
    rst_pulse();
    bus0.req = 4'b0110;
    tick();
    chk("ed_ack0", 32'(bus0.ack), 32'h2);
    tick();
    chk("ed_ack1", 32'(bus0.ack), 32'h2);
    tick();
    bus0.req = 4'b0100;
    #1;
    chk("ed_drop_ack", 32'(bus0.ack), 32'h0);
    chk("ed_drop_grant", 32'(bus0.grant), 32'h2);
    tick();
    chk("ed_next_grant", 32'(bus0.grant), 32'h4);
    chk("ed_next_sel", 32'(bus0.sel), 32'h2);
    chk("ed_next_ack", 32'(bus0.ack), 32'h4);

    // Reset mid-burst: owner 2 at cnt 2, reset acts without a clock edge.
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_grant", 32'(bus0.grant), 32'h0);
    chk("mrst_valid", 32'(bus0.out_valid), 32'h0);
    chk("mrst_sel", 32'(bus0.sel), 32'h0);
    chk("mrst_busy", 32'(bus0.busy), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_idle", 32'(bus0.grant), 32'h0);
    tick();
    chk("mrst_regrant", 32'(bus0.grant), 32'h4);

`ifdef ARB_LOCK_EN
    // Lock: owner 0 keeps the port past the burst limit until lock falls.
    rst_pulse();
    bus0.lock = 4'b0001;
    bus0.req = 4'b0011;
    tick();
    for (int j = 0; j < 6; j++) begin
      chk("lock_ack", 32'(bus0.ack), 32'h1);
      tick();
    end
    bus0.lock = 4'b0000;
    #1;
    chk("lock_last_ack", 32'(bus0.ack), 32'h1);
    tick();
    chk("lock_release", 32'(bus0.grant), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
